bmg_mem_classifier: RTL and testbench

- Storage and decision back-end of the NN inference engine.
- Contains a single-port read/write activation RAM, a read-only weight/bias ROM, and the final two-class output classifier.
- The NN controller fills the RAM with the 1000 input samples and the hidden-layer results, streams weights from the ROM into the MAC neuron, then hands the two output-neuron values to the classifier to obtain a 1-bit category.

---
 rtl/bmg_mem_classifier.sv | 82 ++++++++
 tb/tb_bmg_mem_classifier.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bmg_mem_classifier.sv
// bmg_mem_classifier: storage and decision back-end of the NN inference engine.
// Holds the activation RAM (single port, write-first), the weight/bias ROM and
// the two-class output classifier.
// Optional macro CLS_SIGNED_EN: the classifier compares cls_a/cls_b as signed
// two's-complement values instead of unsigned.
module bmg_mem_classifier #(
  parameter int    DATA_W        = 16,
  parameter int    RAM_AW        = 11,
  parameter int    ROM_AW        = 17,
  parameter int    ROM_DEPTH     = 100400,
  parameter string ROM_INIT_FILE = "weights.hex"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_en,
  input  logic              ram_we,
  input  logic [RAM_AW-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_din,
  output logic [DATA_W-1:0] ram_dout,
  input  logic [ROM_AW-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_dout,
  input  logic              cls_en,
  input  logic [DATA_W-1:0] cls_a,
  input  logic [DATA_W-1:0] cls_b,
  output logic              category,
  output logic              cls_valid
);

  logic [DATA_W-1:0] ram [2**RAM_AW];
  logic [DATA_W-1:0] rom [ROM_DEPTH];
  logic              cls_en_q;
  logic              cls_rise;
  logic              b_wins;

  // ROM image: uninitialised words read 0
  initial begin
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = '0;
  end

  // RAM port: write-first, 1-cycle read, output holds while disabled; array itself is never reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_dout <= '0;
    end else if (ram_en) begin
      if (ram_we) begin
        ram[ram_addr] <= ram_din;
        ram_dout      <= ram_din;
      end else begin
        ram_dout <= ram[ram_addr];
      end
    end
  end

  // ROM port: free-running 1-cycle read, addresses past the populated image return 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               rom_dout <= '0;
    else if (rom_addr < ROM_AW'(ROM_DEPTH))  rom_dout <= rom[rom_addr];
    else                                     rom_dout <= '0;
  end

  assign cls_rise = cls_en & ~cls_en_q;

`ifdef CLS_SIGNED_EN
  assign b_wins = $signed(cls_b) > $signed(cls_a);
`else
  assign b_wins = cls_b > cls_a;
`endif

  // Classifier: evaluate only on a 0->1 of cls_en; ties favour neuron 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls_en_q  <= 1'b0;
      category  <= 1'b0;
      cls_valid <= 1'b0;
    end else begin
      cls_en_q  <= cls_en;
      cls_valid <= cls_rise;
      if (cls_rise) category <= b_wins;
    end
  end

endmodule

// File: tb/tb_bmg_mem_classifier.sv
// Scoreboard bench for bmg_mem_classifier: the driver pushes the expected
// outputs computed by a behavioural model; a monitor pops and compares.
module tb_bmg_mem_classifier;
  localparam int DW = 16, RAW = 11, ROAW = 17, RDEPTH = 100400;

  logic            clk = 0, reset = 0;
  logic            ram_en = 0, ram_we = 0;
  logic [RAW-1:0]  ram_addr = '0;
  logic [DW-1:0]   ram_din = '0, ram_dout;
  logic [ROAW-1:0] rom_addr = '0;
  logic [DW-1:0]   rom_dout;
  logic            cls_en = 0;
  logic [DW-1:0]   cls_a = '0, cls_b = '0;
  logic            category, cls_valid;

  always #5 clk = ~clk;

  bmg_mem_classifier #(.ROM_INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .rom_addr(rom_addr), .rom_dout(rom_dout),
    .cls_en(cls_en), .cls_a(cls_a), .cls_b(cls_b), .category(category), .cls_valid(cls_valid)
  );

  typedef struct {
    logic [DW-1:0] ram;
    logic [DW-1:0] rom;
    logic          cat;
    logic          vld;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;

  // behavioural model state
  logic [DW-1:0] m_ram [2048];
  logic [DW-1:0] m_rom [int];
  int            rom_keys[$];
  logic [DW-1:0] m_ram_out = '0;
  logic          m_cat = 0, m_en_prev = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // neuron 1 wins only if strictly larger, using integer values of the operands
  function automatic bit model_b_wins(logic [DW-1:0] a, logic [DW-1:0] b);
    int va, vb;
    va = int'(a);
    vb = int'(b);
`ifdef CLS_SIGNED_EN
    if (va >= 32768) va = va - 65536;
    if (vb >= 32768) vb = vb - 65536;
`endif
    return vb > va;
  endfunction

  function automatic int pick_rom_addr();
    int r;
    r = $urandom_range(0, 3);
    if (r < 2)  return rom_keys[$urandom_range(0, rom_keys.size() - 1)];
    if (r == 2) return $urandom_range(0, RDEPTH - 1);
    return $urandom_range(RDEPTH, 131071);
  endfunction

  // present one cycle of stimulus and push what the outputs must be after the next edge
  task automatic drive(bit en, bit we, int addr, logic [DW-1:0] din, int raddr,
                       bit ce, logic [DW-1:0] a, logic [DW-1:0] b);
    exp_t e;
    @(negedge clk);
    ram_en = en; ram_we = we; ram_addr = addr[RAW-1:0]; ram_din = din;
    rom_addr = raddr[ROAW-1:0];
    cls_en = ce; cls_a = a; cls_b = b;
    if (en) begin
      if (we) begin
        m_ram[addr] = din;
        m_ram_out   = din;
      end else begin
        m_ram_out = m_ram[addr];
      end
    end
    e.ram = m_ram_out;
    e.rom = (raddr < RDEPTH && m_rom.exists(raddr)) ? m_rom[raddr] : '0;
    e.vld = ce && !m_en_prev;
    if (e.vld) m_cat = model_b_wins(a, b);
    m_en_prev = ce;
    e.cat = m_cat;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left unpopped", exp_q.size());
      exp_q.delete();
    end
  endtask

  // monitor: compare every presented output cycle against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ram_dout", 32'(ram_dout), 32'(e.ram));
        chk("rom_dout", 32'(rom_dout), 32'(e.rom));
        chk("cls_valid", 32'(cls_valid), 32'(e.vld));
        chk("category", 32'(category), 32'(e.cat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, v, ra;
    bit en, we, ce;
    int ad;
    logic [DW-1:0] a, b;

    // power-on reset and ROM image (TB-provided contents, rest stays zero)
    #1 reset = 1;
    dut.rom[0] = 16'h0001;      m_rom[0] = 16'h0001;      rom_keys.push_back(0);
    dut.rom[RDEPTH-1] = 16'h7FFF; m_rom[RDEPTH-1] = 16'h7FFF; rom_keys.push_back(RDEPTH-1);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(1, RDEPTH - 2);
      v = $urandom_range(1, 65535);
      if (!m_rom.exists(k)) begin
        dut.rom[k] = v[DW-1:0];
        m_rom[k]   = v[DW-1:0];
        rom_keys.push_back(k);
      end
    end
    #1;
    chk("rst_ram_dout", 32'(ram_dout), 0);
    chk("rst_rom_dout", 32'(rom_dout), 0);
    chk("rst_category", 32'(category), 0);
    chk("rst_cls_valid", 32'(cls_valid), 0);
    @(negedge clk) reset = 0;

    // RAM fill and readback
    for (int i = 0; i < 1000; i++) drive(1, 1, i, 16'(i + 16'h0100), pick_rom_addr(), 0, 0, 0);
    for (int i = 0; i < 1000; i++) drive(1, 0, i, 16'h0, pick_rom_addr(), 0, 0, 0);
    drive(1, 1, 2047, 16'hBEEF, pick_rom_addr(), 0, 0, 0);
    drive(1, 0, 0, 16'h0, pick_rom_addr(), 0, 0, 0);
    drive(1, 0, 2047, 16'h0, pick_rom_addr(), 0, 0, 0);

    // write-first then disabled hold
    drive(1, 1, 1000, 16'h1234, 0, 0, 0, 0);
    drive(0, 0, 5, 16'hFFFF, 0, 0, 0, 0);
    drive(0, 1, 6, 16'hAAAA, 0, 0, 0, 0);

    // ROM boundaries
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, RDEPTH - 1, 0, 0, 0);
    drive(0, 0, 0, 0, RDEPTH, 0, 0, 0);
    drive(0, 0, 0, 0, 131071, 0, 0, 0);

    // classifier: rise, hold, tie
    drive(0, 0, 0, 0, 0, 0, 16'h0010, 16'h0020);
    drive(0, 0, 0, 0, 0, 1, 16'h0010, 16'h0020);
    drive(0, 0, 0, 0, 0, 1, 16'h0010, 16'h0000);
    drive(0, 0, 0, 0, 0, 1, 16'h0010, 16'h0000);
    drive(0, 0, 0, 0, 0, 0, 16'h0005, 16'h0005);
    drive(0, 0, 0, 0, 0, 1, 16'h0005, 16'h0005);
    drive(0, 0, 0, 0, 0, 0, 16'hFFF0, 16'h0001);
    drive(0, 0, 0, 0, 0, 1, 16'hFFF0, 16'h0001);
    drive(0, 0, 0, 0, 0, 0, 16'h0001, 16'hFFF0);
    drive(0, 0, 0, 0, 0, 1, 16'h0001, 16'hFFF0);

    // randomized mix of all three blocks
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1);
      ad = we ? $urandom_range(0, 2047) : $urandom_range(0, 999);
      ce = $urandom_range(0, 1);
      a  = 16'($urandom_range(0, 65535));
      b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom_range(0, 65535));
      ra = pick_rom_addr();
      drive(en, we, ad, 16'($urandom_range(0, 65535)), ra, ce, a, b);
    end

    // force category=1, then async reset mid-cycle with a write presented
    drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0001);
    drive(1, 0, 3, 0, 0, 1, 16'h0000, 16'h0001);
    drain();
    chk("pre_rst_category", 32'(category), 1);
    @(negedge clk);
    ram_en = 1; ram_we = 1; ram_addr = 11'd3; ram_din = 16'hDEAD; cls_en = 0;
    rom_addr = '0;
    #2 reset = 1;
    #1;
    chk("async_ram_dout", 32'(ram_dout), 0);
    chk("async_rom_dout", 32'(rom_dout), 0);
    chk("async_category", 32'(category), 0);
    chk("async_cls_valid", 32'(cls_valid), 0);
    @(posedge clk);
    @(negedge clk);
    ram_en = 0; ram_we = 0;
    reset = 0;
    m_ram_out = '0; m_cat = 0; m_en_prev = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 3, 0, pick_rom_addr(), 0, 0, 0);
    drive(0, 0, 0, 0, pick_rom_addr(), 1, 16'h0007, 16'h0003);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
